// File: rtl/rom_read_seq.sv
// Burst read sequencer in front of a registered lookup ROM. It issues 1..MAXB
// wrapping addresses, packs the returned beats and offers them on valid/ready.
module rom_read_seq #(
    parameter int AW     = 2,
    parameter int DW     = 2,
    parameter int RD_LAT = 1,
    parameter int MAXB   = 4
) (
    input  logic                clk1,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [2:0]          burst_len,
    input  logic [DW-1:0]       rd_data,
    output logic [AW-1:0]       mem_addr,
    output logic                busy,
    output logic [DW*MAXB-1:0]  out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] idx;
    } tag_t;

    state_t            state, state_d;
    logic [2:0]        len;
    logic [2:0]        clamped_len;
    logic [AW-1:0]     issue_idx;
    logic [AW-1:0]     last_idx;
    tag_t [RD_LAT:0]   tag_pipe;
    tag_t              push_tag;
    tag_t              cap_tag;
    logic              launch;
    logic              advance;
    logic              cap_last;

    assign clamped_len = (burst_len == 3'd0 || burst_len > 3'(MAXB)) ? 3'(MAXB) : burst_len;
    assign last_idx    = AW'(len - 3'd1);

    // The oldest tag lines up with the ROM data for the beat it describes.
    assign cap_tag   = tag_pipe[RD_LAT];
    assign cap_last  = cap_tag.valid && (cap_tag.idx == last_idx);

    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d        = state;
        launch         = 1'b0;
        advance        = 1'b0;
        push_tag.valid = 1'b0;
        push_tag.idx   = '0;
        case (state)
            IDLE:    if (start) begin
                         state_d = ISSUE;
                         launch  = 1'b1;
                     end
            ISSUE:   if (issue_idx == last_idx) state_d = WAIT;
                     else                       advance = 1'b1;
            WAIT:    if (cap_last)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (launch || advance) begin
            push_tag.valid = 1'b1;
            push_tag.idx   = launch ? '0 : AW'(issue_idx + 1'b1);
        end
    end

    // NOTE: the tag pipe is cleared on reset because a stale valid tag would
    // write a discarded beat into the next burst.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            out_data  <= '0;
            len       <= '0;
            issue_idx <= '0;
            tag_pipe  <= '0;
        end else begin
            tag_pipe <= {tag_pipe[RD_LAT-1:0], push_tag};
            if (launch) begin
                len       <= clamped_len;
                mem_addr  <= base_addr;
                issue_idx <= '0;
                out_data  <= '0;
            end else begin
                if (advance) begin
                    mem_addr  <= mem_addr + 1'b1;
                    issue_idx <= issue_idx + 1'b1;
                end
                if (cap_tag.valid)
                    out_data[DW*cap_tag.idx +: DW] <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_read_seq.sv
// Bench for rom_read_seq: two instances (RD_LAT=1 and RD_LAT=2) each fed by a
// registered ROM model; expectations come from the burst rules, not the RTL.
module tb_rom_read_seq;

    logic       clk1 = 1'b0;
    logic       reset_v [2];
    logic       start_v [2];
    logic [1:0] base_v  [2];
    logic [2:0] blen_v  [2];
    logic       ready_v [2];
    logic [1:0] rd_v    [2];
    logic [1:0] addr_v  [2];
    logic       busy_v  [2];
    logic [7:0] od_v    [2];
    logic       ov_v    [2];

    logic [1:0] rom [4];
    logic [1:0] rom_q1;
    logic [1:0] rom_q2a, rom_q2b;

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    // Registered ROM models: one and two cycles of read latency.
    always @(posedge clk1) begin
        rom_q1  <= rom[addr_v[0]];
        rom_q2a <= rom[addr_v[1]];
        rom_q2b <= rom_q2a;
    end
    assign rd_v[0] = rom_q1;
    assign rd_v[1] = rom_q2b;

    rom_read_seq #(.AW(2), .DW(2), .RD_LAT(1), .MAXB(4)) dut0 (
        .clk1(clk1), .reset(reset_v[0]), .start(start_v[0]), .base_addr(base_v[0]),
        .burst_len(blen_v[0]), .rd_data(rd_v[0]), .mem_addr(addr_v[0]), .busy(busy_v[0]),
        .out_data(od_v[0]), .out_valid(ov_v[0]), .out_ready(ready_v[0])
    );

    rom_read_seq #(.AW(2), .DW(2), .RD_LAT(2), .MAXB(4)) dut1 (
        .clk1(clk1), .reset(reset_v[1]), .start(start_v[1]), .base_addr(base_v[1]),
        .burst_len(blen_v[1]), .rd_data(rd_v[1]), .mem_addr(addr_v[1]), .busy(busy_v[1]),
        .out_data(od_v[1]), .out_valid(ov_v[1]), .out_ready(ready_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    function automatic logic [7:0] packed_burst(input logic [1:0] base, input int n);
        logic [7:0] w = '0;
        for (int k = 0; k < n; k++)
            w = w | (8'(rom[(int'(base) + k) % 4]) << (2 * k));
        return w;
    endfunction

    // One complete burst on instance d; hold = cycles of backpressure in HOLD.
    task automatic burst(input int d, input logic [1:0] base, input logic [2:0] blen,
                         input int hold, input bit start_at_xfer, input string name);
        int         n_beats, lat, a;
        logic [7:0] exp;
        n_beats = (blen == 3'd0 || blen > 3'd4) ? 4 : int'(blen);
        lat     = d + 1;
        exp     = packed_burst(base, n_beats);

        start_v[d] = 1'b1;
        base_v[d]  = base;
        blen_v[d]  = blen;
        ready_v[d] = (hold == 0);
        step();                                        // E0
        start_v[d] = 1'b0;
        base_v[d]  = 2'($urandom);
        blen_v[d]  = 3'($urandom);
        check($sformatf("%s d%0d addr@E0", name, d), 32'(addr_v[d]), 32'(base));
        check($sformatf("%s d%0d busy@E0", name, d), 32'(busy_v[d]), 1);
        check($sformatf("%s d%0d clear@E0", name, d), 32'(od_v[d]), 0);

        for (int n = 1; n < n_beats + lat; n++) begin
            step();
            a = (n < n_beats - 1) ? n : n_beats - 1;
            check($sformatf("%s d%0d addr@E%0d", name, d, n), 32'(addr_v[d]),
                  32'((int'(base) + a) % 4));
            check($sformatf("%s d%0d novalid@E%0d", name, d, n), 32'(ov_v[d]), 0);
        end

        step();                                        // E(len+RD_LAT)
        check($sformatf("%s d%0d valid", name, d), 32'(ov_v[d]), 1);
        check($sformatf("%s d%0d data", name, d), 32'(od_v[d]), 32'(exp));

        for (int h = 0; h < hold; h++) begin
            start_v[d] = (h == hold / 2);
            step();
            start_v[d] = 1'b0;
            check($sformatf("%s d%0d hold valid h%0d", name, d, h), 32'(ov_v[d]), 1);
            check($sformatf("%s d%0d hold data h%0d", name, d, h), 32'(od_v[d]), 32'(exp));
        end

        ready_v[d] = 1'b1;
        start_v[d] = start_at_xfer;
        step();
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
        check($sformatf("%s d%0d valid drop", name, d), 32'(ov_v[d]), 0);
        check($sformatf("%s d%0d idle", name, d), 32'(busy_v[d]), 0);
        check($sformatf("%s d%0d data kept", name, d), 32'(od_v[d]), 32'(exp));
        step();
        check($sformatf("%s d%0d no queued start", name, d), 32'(busy_v[d]), 0);
    endtask

    // Start held high with len=1: one transfer every RD_LAT+3 cycles.
    task automatic back_to_back(input int d, input logic [1:0] base);
        int per, lat;
        lat        = d + 1;
        per        = lat + 3;
        start_v[d] = 1'b1;
        base_v[d]  = base;
        blen_v[d]  = 3'd1;
        ready_v[d] = 1'b1;
        step();
        for (int n = 1; n <= 40; n++) begin
            step();
            check($sformatf("b2b d%0d valid@%0d", d, n), 32'(ov_v[d]),
                  32'((n % per) == lat + 1));
            if ((n % per) == lat + 1)
                check($sformatf("b2b d%0d data@%0d", d, n), 32'(od_v[d]), 32'(rom[base]));
        end
        start_v[d] = 1'b0;
        for (int n = 0; n < per; n++) step();
        ready_v[d] = 1'b0;
        check($sformatf("b2b d%0d drained", d), 32'(busy_v[d]), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_v[d] = 1'b1;
            start_v[d] = 1'b0;
            base_v[d]  = '0;
            blen_v[d]  = '0;
            ready_v[d] = 1'b0;
        end
        for (int i = 0; i < 4; i++) rom[i] = 2'(i);

        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset d%0d addr", d), 32'(addr_v[d]), 0);
            check($sformatf("reset d%0d busy", d), 32'(busy_v[d]), 0);
            check($sformatf("reset d%0d valid", d), 32'(ov_v[d]), 0);
            check($sformatf("reset d%0d data", d), 32'(od_v[d]), 0);
        end
        repeat (2) @(negedge clk1);
        reset_v[0] = 1'b0;
        reset_v[1] = 1'b0;
        @(negedge clk1);

        burst(0, 2'd2, 3'd1, 0, 1'b0, "single");
        burst(0, 2'd1, 3'd0, 0, 1'b0, "wrap");
        burst(0, 2'd0, 3'd2, 10, 1'b1, "backpressure");
        burst(1, 2'd3, 3'd7, 2, 1'b0, "clamp");

        // Asynchronous reset while the len=4 burst is still issuing.
        start_v[0] = 1'b1;
        base_v[0]  = 2'd2;
        blen_v[0]  = 3'd4;
        step();
        start_v[0] = 1'b0;
        repeat (3) step();
        #2;
        reset_v[0] = 1'b1;
        #1;
        check("midreset addr", 32'(addr_v[0]), 0);
        check("midreset busy", 32'(busy_v[0]), 0);
        check("midreset valid", 32'(ov_v[0]), 0);
        check("midreset data", 32'(od_v[0]), 0);
        @(negedge clk1);
        reset_v[0] = 1'b0;
        @(negedge clk1);
        burst(0, 2'd1, 3'd1, 0, 1'b0, "after reset");

        for (int i = 0; i < 4; i++) rom[i] = 2'($urandom);
        back_to_back(0, 2'($urandom));
        back_to_back(1, 2'($urandom));

        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < 4; j++) rom[j] = 2'($urandom);
            burst(i % 2, 2'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
